i2s_transmitter: RTL and testbench
==================================

// Module: i2s_transmitter
// PURPOSE
//  Stereo I2S serializer and clock master. It sits directly downstream of the sine/tone generators.
//  It generates bclk and lrclk from a system clock; the lrclk output also clocks the generator stage.
//  It latches one left and one right sample per frame and shifts them MSB-first onto dout for the codec.
// PARAMETERS
//  BITSIZE    24  sample width, two's complement; must be < FRAMEBITS
//  FRAMEBITS  32  bclk periods per channel slot; a frame is 2*FRAMEBITS bclks
//  BCLKDIV     4  clk cycles per bclk half-period; must be >= 1
// PORTS
//  clk         in   1        system clock; all state updates on posedge
//  reset       in   1        synchronous, active-high
//  left_in     in   BITSIZE  left sample; must be stable while sample_ack is high
//  right_in    in   BITSIZE  right sample; must be stable while sample_ack is high
//  sample_ack  out  1        one-clk pulse: left_in/right_in latched this cycle
//  bclk        out  1        bit clock, period 2*BCLKDIV clk
//  lrclk       out  1        0 = left slot, 1 = right slot; also the generator sample clock
//  dout        out  1        serial data; changes only on bclk falling transitions
// BEHAVIOUR
//  - Reset values: bclk=0, lrclk=0, dout=0, sample_ack=0, divcnt=0, bitcnt=2*FRAMEBITS-1, holding regs=0.
//  - Reset mid-frame aborts the frame. Outputs take reset values on the next clk edge.
//  - divcnt counts 0..BCLKDIV-1. At the terminal count bclk toggles and divcnt wraps to 0.
//  - The first bclk rise occurs BCLKDIV clks after reset deasserts; the first fall occurs 2*BCLKDIV clks after.
//  - On each fall, i.e. the clk edge that writes bclk 1->0, the counter advances:
//    bitcnt <= (bitcnt==2*FRAMEBITS-1) ? 0 : bitcnt+1, width $clog2(2*FRAMEBITS).
//  - On the same edge: lrclk <= (next bitcnt >= FRAMEBITS), and dout <= bit for slot position p = next bitcnt mod FRAMEBITS.
//  - Standard I2S data: dout = chan[BITSIZE-p] for 1 <= p <= BITSIZE, else 0.
//    MSB lags the lrclk edge by one bclk; p=0 always sends 0.
//  - chan is the left holding reg while lrclk=0, the right holding reg while lrclk=1.
//  - Latch: on the fall that enters bitcnt=0, both holding regs load left_in/right_in.
//    dout for p=0 uses the new values; in I2S mode it is 0 regardless.
//    sample_ack=1 for exactly that clk, then 0. Exactly one ack per frame.
//  - Input changes between acks have no effect on the frame in flight.
//  - Implementation: a shift register loaded at the slot start is permitted if dout is bit-identical.
//  - The generator stage updates on the lrclk rise (right slot start).
//    That gives >= FRAMEBITS bclks of settling before the next latch.
//  - No back-pressure: samples not refreshed are retransmitted unchanged.
// CONFIGURATION
//  LEFT_JUSTIFIED_EN defined:
//    dout = chan[BITSIZE-1-p] for p < BITSIZE, else 0; the MSB is coincident with the lrclk edge.
//    Latch and sample_ack timing are unchanged.
//  LEFT_JUSTIFIED_EN undefined: standard I2S one-bclk-delay format as above.
// TESTING (defaults BITSIZE=24, FRAMEBITS=32, BCLKDIV=4)
//  1. Reset held 5 clks, then released.
//     -> All outputs 0 during reset. The first bclk rise is at clk 4 and the first fall at clk 8 after release.
//     -> Then bclk has period 8 clk, duty 50%.
//  2. left_in=24'h800001, right_in=24'h7FFFFF, I2S.
//     -> lrclk low for 32 bclk, then high for 32.
//     -> dout sampled on bclk rise: left p1..p24 = 1000_0000_0000_0000_0000_0001, right p1..p24 = 0111_1111_1111_1111_1111_1111.
//     -> p0 and p25..p31 are 0 in both slots.
//  3. Same stimulus with LEFT_JUSTIFIED_EN.
//     -> The left MSB=1 appears at p0, the same bclk as the lrclk fall. p24..p31 are 0.
//  4. Change left_in to 24'h123456 at bitcnt=10.
//     -> The current frame still sends 24'h800001.
//     -> The next frame sends 24'h123456. sample_ack pulses every 512 clk, 1 clk wide.
//  5. Assert reset for 1 clk at bitcnt=40 (right slot).
//     -> Next clk: bclk=lrclk=dout=0.
//     -> After release: the first fall enters bitcnt=0 with lrclk=0 and sample_ack=1. No partial right slot is resumed.

Source files
------------

// File: rtl/i2s_if.sv
// Stereo sample input and serial I2S output bundle of the transmitter.
// master = transmitter side, slave = generator/codec side.
interface i2s_if #(
  parameter int BITSIZE = 24
);
  logic [BITSIZE-1:0] left_in;
  logic [BITSIZE-1:0] right_in;
  logic               sample_ack;
  logic               bclk;
  logic               lrclk;
  logic               dout;

  modport master (
    input  left_in, right_in,
    output sample_ack, bclk, lrclk, dout
  );

  modport slave (
    output left_in, right_in,
    input  sample_ack, bclk, lrclk, dout
  );
endinterface

// File: rtl/i2s_transmitter.sv
// Stereo I2S serializer and bclk/lrclk master; latches one L/R pair per frame, MSB first on dout.
// Define LEFT_JUSTIFIED_EN for left-justified framing (MSB coincident with the lrclk edge).
module i2s_transmitter #(
  parameter int BITSIZE   = 24,
  parameter int FRAMEBITS = 32,
  parameter int BCLKDIV   = 4
) (
  input  logic  clk,
  input  logic  reset,
  i2s_if.master bus
);
  localparam int CW = $clog2(2*FRAMEBITS);
  localparam int DW = (BCLKDIV > 1) ? $clog2(BCLKDIV) : 1;
  localparam int IW = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;
  localparam logic [CW-1:0] LASTBIT = CW'(2*FRAMEBITS-1);
  localparam logic [DW-1:0] DIVLAST = DW'(BCLKDIV-1);

  logic [DW-1:0]      r_divcnt;
  logic [CW-1:0]      r_bitcnt;
  logic               r_bclk;
  logic               r_lrclk;
  logic               r_dout;
  logic               r_ack;
  logic [BITSIZE-1:0] r_left;
  logic [BITSIZE-1:0] r_right;

  logic               w_fall;
  logic               w_latch;
  logic               w_right;
  logic               w_bit;
  logic [CW-1:0]      w_nbit;
  logic [CW-1:0]      w_pos;
  logic [IW-1:0]      w_idx;
  logic [BITSIZE-1:0] w_chan;

  // Next-bit selection for the bclk fall; the latch edge serializes the fresh left_in.
  always_comb begin
    w_fall  = (r_divcnt == DIVLAST) && r_bclk;
    w_nbit  = (r_bitcnt == LASTBIT) ? '0 : r_bitcnt + 1'b1;
    w_latch = (w_nbit == '0);
    w_right = (int'(w_nbit) >= FRAMEBITS);
    w_pos   = w_right ? w_nbit - CW'(FRAMEBITS) : w_nbit;
    w_chan  = w_latch ? bus.left_in : (w_right ? r_right : r_left);
    w_idx   = '0;
    w_bit   = 1'b0;
`ifdef LEFT_JUSTIFIED_EN
    if (int'(w_pos) < BITSIZE) begin
      w_idx = IW'(BITSIZE - 1 - int'(w_pos));
      w_bit = w_chan[w_idx];
    end
`else
    if ((w_pos != '0) && (int'(w_pos) <= BITSIZE)) begin
      w_idx = IW'(BITSIZE - int'(w_pos));
      w_bit = w_chan[w_idx];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_divcnt <= '0;
      r_bitcnt <= LASTBIT;
      r_bclk   <= 1'b0;
      r_lrclk  <= 1'b0;
      r_dout   <= 1'b0;
      r_ack    <= 1'b0;
      r_left   <= '0;
      r_right  <= '0;
    end else begin
      r_ack <= 1'b0;
      if (r_divcnt == DIVLAST) begin
        r_divcnt <= '0;
        r_bclk   <= ~r_bclk;
      end else begin
        r_divcnt <= r_divcnt + 1'b1;
      end
      if (w_fall) begin
        r_bitcnt <= w_nbit;
        r_lrclk  <= w_right;
        r_dout   <= w_bit;
        if (w_latch) begin
          r_left  <= bus.left_in;
          r_right <= bus.right_in;
          r_ack   <= 1'b1;
        end
      end
    end
  end

  assign bus.bclk       = r_bclk;
  assign bus.lrclk      = r_lrclk;
  assign bus.dout       = r_dout;
  assign bus.sample_ack = r_ack;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at BITSIZE=24, FRAMEBITS=32, BCLKDIV=4.
// Slot words are dout sampled on bclk rises, p0 in bit 31.
module tb_i2s_transmitter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

`ifdef LEFT_JUSTIFIED_EN
  localparam logic [31:0] EXP_L1 = 32'h8000_0100;
  localparam logic [31:0] EXP_R1 = 32'h7FFF_FF00;
  localparam logic [31:0] EXP_L3 = 32'h1234_5600;
`else
  localparam logic [31:0] EXP_L1 = 32'h4000_0080;
  localparam logic [31:0] EXP_R1 = 32'h3FFF_FF80;
  localparam logic [31:0] EXP_L3 = 32'h091A_2B00;
`endif

  i2s_if #(.BITSIZE(24)) bus();

  i2s_transmitter #(.BITSIZE(24), .FRAMEBITS(32), .BCLKDIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Records the cycle of every sample_ack and any ack longer than one clk.
  int   cyc      = 0;
  int   ack_t[$];
  int   ack_wide = 0;
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (bus.sample_ack === 1'b1) begin
      if (ack_prev) ack_wide++;
      ack_t.push_back(cyc);
    end
    ack_prev = bus.sample_ack;
  end

  task automatic wait_rise(output bit ok, output int polls, output int highs);
    logic prev;
    prev  = bus.bclk;
    ok    = 1'b0;
    polls = 0;
    highs = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      polls++;
      if (bus.bclk === 1'b1) highs++;
      if (prev === 1'b0 && bus.bclk === 1'b1) ok = 1'b1;
      prev = bus.bclk;
    end
  endtask

  // Called on the negedge where reset has just been dropped.
  task automatic release_pat(input string tag);
    logic [7:0] pat;
    pat = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      pat = {pat[6:0], bus.bclk};
    end
    chk({tag, "_bclk_pat"}, 64'(pat), 64'(8'b0001_1110));
    chk({tag, "_lrclk"}, 64'(bus.lrclk), 64'd0);
    chk({tag, "_ack"}, 64'(bus.sample_ack), 64'd1);
  endtask

  task automatic frame(input bit chg, input logic [31:0] el, input logic [31:0] er, input string tag);
    logic [31:0] lw, rw, ll, rl;
    bit ok;
    int p, h, nto, pmin, pmax, hmin, hmax;
    lw = '0; rw = '0; ll = '0; rl = '0;
    nto = 0; pmin = 999; pmax = 0; hmin = 999; hmax = 0;
    for (int k = 0; k < 64; k++) begin
      wait_rise(ok, p, h);
      if (!ok) nto++;
      if (k > 0) begin
        if (p < pmin) pmin = p;
        if (p > pmax) pmax = p;
        if (h < hmin) hmin = h;
        if (h > hmax) hmax = h;
      end
      if (k < 32) begin
        lw[31-k] = bus.dout;
        ll[31-k] = bus.lrclk;
      end else begin
        rw[63-k] = bus.dout;
        rl[63-k] = bus.lrclk;
      end
      if (chg && k == 10) bus.left_in = 24'h123456;
    end
    chk({tag, "_waits"}, 64'(nto), 64'd0);
    chk({tag, "_period"}, {32'(pmin), 32'(pmax)}, {32'd8, 32'd8});
    chk({tag, "_duty"}, {32'(hmin), 32'(hmax)}, {32'd4, 32'd4});
    chk({tag, "_left"}, 64'(lw), 64'(el));
    chk({tag, "_right"}, 64'(rw), 64'(er));
    chk({tag, "_lr_left"}, 64'(ll), 64'h0);
    chk({tag, "_lr_right"}, 64'(rl), 64'hFFFF_FFFF);
  endtask

  initial begin
    bit ok;
    int p, h;
    bus.left_in  = 24'h800001;
    bus.right_in = 24'h7FFFFF;
    reset        = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_out", 64'({bus.bclk, bus.lrclk, bus.dout, bus.sample_ack}), 64'd0);
    end
    reset = 1'b0;
    release_pat("start");

    frame(1'b0, EXP_L1, EXP_R1, "f1");
    frame(1'b1, EXP_L1, EXP_R1, "f2");
    frame(1'b0, EXP_L3, EXP_R1, "f3");

    chk("ack_count", 64'(ack_t.size()), 64'd3);
    if (ack_t.size() >= 3) begin
      chk("ack_gap1", 64'(ack_t[1] - ack_t[0]), 64'd512);
      chk("ack_gap2", 64'(ack_t[2] - ack_t[1]), 64'd512);
    end
    chk("ack_width", 64'(ack_wide), 64'd0);

    // Abort in the right slot at bitcnt 40.
    for (int k = 0; k <= 40; k++) wait_rise(ok, p, h);
    chk("pre_rst_lrclk", 64'(bus.lrclk), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid", 64'({bus.bclk, bus.lrclk, bus.dout, bus.sample_ack}), 64'd0);
    reset = 1'b0;
    release_pat("restart");
    frame(1'b0, EXP_L3, EXP_R1, "f5");
    chk("ack_width_end", 64'(ack_wide), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
